fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the accumulator CPU; sits directly upstream of the controller FSM.
- Owns the program counter (PC) and instruction register (IR), and applies the controller's LoadPC/SelPC/IncPC/LoadIR strobes.
- Fetches instructions from program memory over a req/ack handshake with variable latency.
- Presents the current Opcode and immediate field back to the controller.

Parameters:
ADDR_W, 8, PC and program-memory address width (bits)
INSTR_W, 8, instruction width; Opcode = IR[INSTR_W-1 -: 4], Imm = IR[INSTR_W-5:0]
RESET_PC, 0, PC value loaded on reset
TIMEOUT, 15, max cycles spent waiting for mem_ack before a fetch is aborted (>=1)

Ports:
CLK  in  1  system clock, rising edge
CLB  in  1  asynchronous active-high reset
LoadPC  in  1  controller: load PC from branch source this cycle
SelPC  in  1  controller: branch source, 0 = RegIn, 1 = zero-extended Imm
IncPC  in  1  controller: increment PC this cycle
LoadIR  in  1  controller: start a fetch at the current PC
RegIn  in  ADDR_W  register-file value, used as branch target when SelPC=0
mem_req  out  1  fetch request to program memory
mem_addr  out  ADDR_W  fetch address; stable while mem_req=1
mem_rdata  in  INSTR_W  instruction word; valid when mem_ack=1
mem_ack  in  1  memory response strobe
PC  out  ADDR_W  current program counter
Opcode  out  4  IR opcode field, feeds controller
Imm  out  INSTR_W-4  IR immediate field
IrValid  out  1  one-cycle pulse: IR updated by a completed fetch
Busy  out  1  fetch in progress
Fault  out  1  sticky: a fetch timed out

Behaviour:
- Clock and reset: single clock CLK, all state on its rising edge. CLB is asynchronous and active-high and overrides everything.
- Reset values:
  - PC = RESET_PC; IR = 0, so Opcode = 0000 (No-Op) and Imm = 0.
  - FSM = IDLE; mem_req = 0, mem_addr = 0.
  - IrValid = 0, Busy = 0, Fault = 0, timeout counter = 0.
- PC update, every cycle, independent of the fetch FSM:
  - LoadPC=1 and SelPC=1: PC <= zero-extend(Imm) to ADDR_W; truncate if ADDR_W < INSTR_W-4.
  - LoadPC=1 and SelPC=0: PC <= RegIn.
  - Else IncPC=1: PC <= PC+1, wrapping modulo 2^ADDR_W (all-ones -> 0).
  - Else PC holds.
  - LoadPC beats IncPC when both are 1.
- Fetch FSM, states IDLE and WAIT:
  - IDLE: mem_req=0, Busy=0. LoadIR=1 -> latch mem_addr <= PC (pre-update value of that edge), clear timeout counter, go to WAIT.
  - WAIT: mem_req=1, Busy=1; mem_addr held constant; LoadIR ignored (no queueing).
  - WAIT, mem_ack=1: IR <= mem_rdata, IrValid=1 for exactly the next cycle, go to IDLE.
  - WAIT, mem_ack=0: counter increments.
  - WAIT, counter reaches TIMEOUT with no ack: IR <= 0 (No-Op), Fault <= 1, IrValid pulses, go to IDLE.
  - mem_ack on the same edge the counter reaches TIMEOUT: the ack wins, normal completion, Fault unchanged.
  - mem_ack while in IDLE: ignored; IR unchanged.
- Latency: LoadIR sampled at edge N -> mem_req high from N. An ack sampled at edge N+k updates IR at N+k; IrValid is high during cycle N+k (until edge N+k+1). Minimum k = 1.
- PC changes during WAIT do not alter mem_addr.
- Fault clears only on CLB.
- Reset mid-fetch: FSM returns to IDLE at once, mem_req drops asynchronously, and any late ack is ignored.
- Opcode and Imm are combinational slices of IR, stable between IrValid pulses.

Test Plan:
- Reset then release; LoadIR=1 for one cycle; memory acks after 1 cycle with 8'h1D -> mem_addr=0, Opcode=0001, Imm=0xD, one IrValid pulse, PC still 0.
- IncPC=1 for 256 cycles from PC=8'hFE -> sequence FE, FF, 00, 01, ...; confirms wrap.
- LoadPC=1, SelPC=1 with Imm=0x7 and IncPC=1 in the same cycle -> PC=0x07 next edge; then LoadPC=1, SelPC=0, RegIn=0x42 -> PC=0x42.
- LoadIR at PC=0x10; ack delayed 5 cycles; IncPC pulsed and a second LoadIR issued during the wait -> mem_addr stays 0x10, second LoadIR ignored, Busy high for 5 cycles, single IrValid.
- No ack for 15 cycles -> IR=0 (No-Op), Fault=1 and sticky. Next fetch acked normally -> IR updated, Fault still 1.
- Assert CLB mid-WAIT with ack arriving 1 cycle later -> mem_req=0 immediately, PC=RESET_PC, IR=0, no IrValid.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, fetches from program memory over a
// req/ack handshake with a bounded wait, and presents Opcode/Imm to the controller.
//
// state  | meaning
// S_IDLE | no fetch outstanding; LoadIR starts one at the current PC
// S_WAIT | mem_req asserted, waiting for mem_ack or timeout
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 8,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic                 CLK,
    input  logic                 CLB,
    input  logic                 LoadPC,
    input  logic                 SelPC,
    input  logic                 IncPC,
    input  logic                 LoadIR,
    input  logic [ADDR_W-1:0]    RegIn,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [INSTR_W-1:0]   mem_rdata,
    input  logic                 mem_ack,
    output logic [ADDR_W-1:0]    PC,
    output logic [3:0]           Opcode,
    output logic [INSTR_W-5:0]   Imm,
    output logic                 IrValid,
    output logic                 Busy,
    output logic                 Fault
);

    localparam int IMM_W = INSTR_W - 4;
    localparam int CW    = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                fault_q, fault_d;
    logic [ADDR_W-1:0]   imm_ext;

    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            state_q <= S_IDLE;
            pc_q    <= ADDR_W'(RESET_PC);
            addr_q  <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    // Branch target from the immediate: zero-extended, or truncated if wider than PC.
    always_comb begin
        imm_ext = ADDR_W'(ir_q[IMM_W-1:0]);
    end

    always_comb begin
        pc_d = pc_q;
        if (LoadPC) begin
            pc_d = SelPC ? imm_ext : RegIn;
        end else if (IncPC) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (LoadIR) begin
                    addr_d  = pc_q;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack on the timeout edge still counts as a normal completion.
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        ir_d    = '0;
                        fault_d = 1'b1;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req  = (state_q == S_WAIT);
    assign Busy     = (state_q == S_WAIT);
    assign mem_addr = addr_q;
    assign PC       = pc_q;
    assign Opcode   = ir_q[INSTR_W-1 -: 4];
    assign Imm      = ir_q[IMM_W-1:0];
    assign IrValid  = valid_q;
    assign Fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of PC, fetch outcome and memory latency.
module tb_fetch_unit;

    localparam int ADDR_W   = 8;
    localparam int INSTR_W  = 8;
    localparam int RESET_PC = 0;
    localparam int TIMEOUT  = 15;

    logic               CLK = 1'b0;
    logic               CLB;
    logic               LoadPC, SelPC, IncPC, LoadIR;
    logic [ADDR_W-1:0]  RegIn;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_ack;
    logic [ADDR_W-1:0]  PC;
    logic [3:0]         Opcode;
    logic [INSTR_W-5:0] Imm;
    logic               IrValid, Busy, Fault;

    fetch_unit #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .CLB(CLB), .LoadPC(LoadPC), .SelPC(SelPC), .IncPC(IncPC),
        .LoadIR(LoadIR), .RegIn(RegIn), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .PC(PC), .Opcode(Opcode),
        .Imm(Imm), .IrValid(IrValid), .Busy(Busy), .Fault(Fault)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a fetch is either outstanding or not; an outstanding
    // fetch knows its address and how many cycles it has gone unanswered.
    int  m_pc, m_ir, m_addr, m_wait, lat;
    bit  m_busy, m_valid, m_fault;
    bit  auto_mem;
    int  valid_seen, busy_seen;
    logic [7:0] prog [256];

    task automatic m_reset();
        m_pc = RESET_PC; m_ir = 0; m_addr = 0; m_wait = 0;
        m_busy = 0; m_valid = 0; m_fault = 0;
    endtask

    function automatic int pick_lat();
        int r;
        r = int'($urandom % 10);
        if (r == 0) return 0;          // never answers -> timeout
        if (r == 1) return TIMEOUT;    // ack exactly on the timeout edge
        if (r == 2) return TIMEOUT - 1;
        return int'($urandom_range(1, 5));
    endfunction

    task automatic check_all();
        chk("pc", PC, m_pc);
        chk("mem_req", mem_req, m_busy);
        chk("busy", Busy, m_busy);
        chk("mem_addr", mem_addr, m_addr);
        chk("opcode", Opcode, (m_ir >> 4) & 15);
        chk("imm", Imm, m_ir & 15);
        chk("irvalid", IrValid, m_valid);
        chk("fault", Fault, m_fault);
    endtask

    task automatic tick();
        int nxt_pc;
        if (auto_mem) begin
            if (m_busy) begin
                mem_ack   = (lat != 0) && (m_wait + 1 == lat);
                mem_rdata = prog[m_addr];
            end else begin
                mem_ack   = ($urandom % 8) == 0;
                mem_rdata = 8'($urandom);
            end
        end
        @(posedge CLK);
        if (CLB) begin
            m_reset();
        end else begin
            if (LoadPC) nxt_pc = SelPC ? (m_ir & 15) : int'(RegIn);
            else if (IncPC) nxt_pc = (m_pc + 1) % 256;
            else nxt_pc = m_pc;
            m_valid = 0;
            if (!m_busy) begin
                if (LoadIR) begin
                    m_busy = 1; m_addr = m_pc; m_wait = 0; lat = pick_lat();
                end
            end else if (mem_ack) begin
                m_ir = int'(mem_rdata); m_valid = 1; m_busy = 0;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_ir = 0; m_fault = 1; m_valid = 1; m_busy = 0;
                end
            end
            m_pc = nxt_pc;
        end
        #1;
        check_all();
        valid_seen += int'(IrValid);
        busy_seen  += int'(Busy);
        @(negedge CLK);
    endtask

    initial begin
        CLB = 1'b1; LoadPC = 0; SelPC = 0; IncPC = 0; LoadIR = 0;
        RegIn = '0; mem_ack = 0; mem_rdata = '0; auto_mem = 0;
        valid_seen = 0; busy_seen = 0; lat = 0;
        for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
        m_reset();
        repeat (3) @(negedge CLK);
        check_all();
        chk("rst_ir", {Opcode, Imm}, 8'h00);
        CLB = 1'b0;

        // First fetch, one-cycle ack
        LoadIR = 1; tick();
        chk("t1_addr", mem_addr, 8'h00);
        LoadIR = 0; mem_ack = 1; mem_rdata = 8'h1D; valid_seen = 0; tick();
        chk("t1_op", Opcode, 4'h1);
        chk("t1_imm", Imm, 4'hD);
        chk("t1_pc", PC, 8'h00);
        mem_ack = 0; tick();
        chk("t1_pulses", valid_seen, 1);

        // PC wrap
        LoadPC = 1; SelPC = 0; RegIn = 8'hFE; tick();
        LoadPC = 0; IncPC = 1;
        tick(); chk("t2_ff", PC, 8'hFF);
        tick(); chk("t2_00", PC, 8'h00);
        repeat (254) tick();
        chk("t2_full", PC, 8'hFE);
        IncPC = 0;

        // Branch sources and LoadPC priority over IncPC
        LoadIR = 1; tick();
        LoadIR = 0; mem_ack = 1; mem_rdata = 8'h07; tick();
        mem_ack = 0; LoadPC = 1; SelPC = 1; IncPC = 1; tick();
        chk("t3_imm_pc", PC, 8'h07);
        SelPC = 0; IncPC = 0; RegIn = 8'h42; tick();
        chk("t3_reg_pc", PC, 8'h42);
        LoadPC = 0;

        // Delayed ack with PC activity and an ignored LoadIR during the wait
        LoadPC = 1; RegIn = 8'h10; tick();
        LoadPC = 0; LoadIR = 1; busy_seen = 0; valid_seen = 0; tick();
        LoadIR = 0; tick();
        IncPC = 1; tick();
        IncPC = 0; LoadIR = 1; tick();
        LoadIR = 0; tick();
        chk("t4_addr", mem_addr, 8'h10);
        chk("t4_pc", PC, 8'h11);
        mem_ack = 1; mem_rdata = 8'hA5; tick();
        mem_ack = 0; tick(); tick();
        chk("t4_busy_cycles", busy_seen, 5);
        chk("t4_pulses", valid_seen, 1);
        chk("t4_op", Opcode, 4'hA);

        // Timeout then a normal fetch; Fault stays set
        LoadIR = 1; tick();
        LoadIR = 0; repeat (TIMEOUT) tick();
        chk("t5_fault", Fault, 1'b1);
        chk("t5_valid", IrValid, 1'b1);
        chk("t5_nop", {Opcode, Imm}, 8'h00);
        LoadIR = 1; tick();
        LoadIR = 0; mem_ack = 1; mem_rdata = 8'h3C; tick();
        mem_ack = 0;
        chk("t5_op", Opcode, 4'h3);
        chk("t5_sticky", Fault, 1'b1);

        // Randomized traffic
        auto_mem = 1;
        repeat (3000) begin
            LoadPC = ($urandom % 8) == 0;
            SelPC  = 1'($urandom);
            IncPC  = ($urandom % 3) == 0;
            LoadIR = ($urandom % 3) == 0;
            RegIn  = 8'($urandom);
            tick();
        end
        auto_mem = 0;
        LoadPC = 0; SelPC = 0; IncPC = 0; LoadIR = 0; mem_ack = 0;
        repeat (TIMEOUT + 2) tick();

        // Reset in the middle of a wait, with a late ack
        LoadIR = 1; tick();
        LoadIR = 0; tick();
        #2 CLB = 1'b1;
        #1;
        chk("t6_req_async", mem_req, 1'b0);
        chk("t6_busy_async", Busy, 1'b0);
        chk("t6_pc_async", PC, RESET_PC);
        chk("t6_ir_async", {Opcode, Imm}, 8'h00);
        chk("t6_fault_async", Fault, 1'b0);
        m_reset();
        mem_ack = 1; mem_rdata = 8'hFF; tick();
        CLB = 1'b0; valid_seen = 0; tick();
        mem_ack = 0; tick();
        chk("t6_late_ack", {Opcode, Imm}, 8'h00);
        chk("t6_no_pulse", valid_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
